// File: rtl/core_pkg.sv
// Shared types for the memory-access stage: FSM states, write-back source
// encodings and the captured token layout.
package core_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned UART_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_WAIT  = 2'd1,
    UART_WAIT = 2'd2,
    DONE      = 2'd3
  } mem_state_t;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_UART = 2'd3;

  // link is stored pre-extended so the token layout is independent of PC width
  typedef struct packed {
    logic              aorf;
    logic              regwrite;
    logic              memwrite;
    logic              memread;
    logic              uarttoreg;
    logic [1:0]        memtoreg;
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   register_data;
    logic [REG_AW-1:0] rdist;
    logic [XLEN-1:0]   link;
  } tok_t;

endpackage

// File: rtl/wb_sel.sv
// Combinational 4:1 write-back source multiplexer; a UART token always
// selects the UART byte regardless of its MemtoReg field.
module wb_sel
  import core_pkg::*;
(
  input  logic [1:0]      memtoreg,
  input  logic            uarttoreg,
  input  logic [XLEN-1:0] alu_data,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] link_data,
  input  logic [XLEN-1:0] uart_data,
  output logic [XLEN-1:0] wb_data_c
);

  logic [1:0] sel_c;

  always_comb begin
    sel_c     = uarttoreg ? WB_UART : memtoreg;
    wb_data_c = alu_data;
    case (sel_c)
      WB_ALU:  wb_data_c = alu_data;
      WB_MEM:  wb_data_c = mem_data;
      WB_LINK: wb_data_c = link_data;
      WB_UART: wb_data_c = uart_data;
      default: wb_data_c = alu_data;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: data-memory load/store or UART receive per token, then a
// single registered write-back strobe. UART receive is built only with MEM_ACCESS_UART_RX_EN.
module mem_access
  import core_pkg::*;
#(
  parameter int unsigned INST_MEM_WIDTH = 5,
  parameter int unsigned DATA_MEM_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      distinct,
  input  logic                      AorF,
  input  logic                      RegWrite,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic                      UARTtoReg,
  input  logic [1:0]                MemtoReg,
  input  logic [31:0]               result,
  input  logic [31:0]               register_data,
  input  logic [4:0]                rdist,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  output logic                      ready,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [DATA_MEM_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  input  logic                      mem_ack,
  input  logic                      uart_rx_valid,
  input  logic [7:0]                uart_rx_data,
  output logic                      uart_rx_pop,
  output logic                      wb_valid,
  output logic                      wb_regwrite,
  output logic                      wb_AorF,
  output logic [4:0]                wb_rdist,
  output logic [31:0]               wb_data
);

  mem_state_t state_q, state_d;
  tok_t       act_q, act_d;
  tok_t       skid_q, skid_d;
  logic       skid_full_q, skid_full_d;
  logic       ready_q, ready_d;
  logic       mem_req_q, mem_req_d;
  logic       mem_we_q, mem_we_d;
  logic [DATA_MEM_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic       uart_rx_pop_q, uart_rx_pop_d;
  logic       wb_valid_q, wb_valid_d;
  logic       wb_regwrite_q, wb_regwrite_d;
  logic       wb_aorf_q, wb_aorf_d;
  logic [REG_AW-1:0] wb_rdist_q, wb_rdist_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  tok_t            in_tok_c;
  tok_t            tok_c;
  logic            accept_c;
  logic            start_c;
  logic            go_done_c;
  logic [XLEN-1:0] mem_data_c;
  logic [XLEN-1:0] uart_data_c;
  logic [XLEN-1:0] wb_data_c;

  always_comb begin
    in_tok_c = '{aorf: AorF, regwrite: RegWrite, memwrite: MemWrite, memread: MemRead,
                 uarttoreg: UARTtoReg, memtoreg: MemtoReg, result: result,
                 register_data: register_data, rdist: rdist, link: XLEN'(pc1)};
  end

`ifndef MEM_ACCESS_UART_RX_EN
  logic unused_uart_c;
  assign unused_uart_c = ^{uart_rx_valid, uart_rx_data};
`endif

  wb_sel u_wb_sel (
    .memtoreg  (tok_c.memtoreg),
    .uarttoreg (tok_c.uarttoreg),
    .alu_data  (tok_c.result),
    .mem_data  (mem_data_c),
    .link_data (tok_c.link),
    .uart_data (uart_data_c),
    .wb_data_c (wb_data_c)
  );

  // Next-state, skid capture and registered output values
  always_comb begin
    state_d       = state_q;
    act_d         = act_q;
    skid_d        = skid_q;
    skid_full_d   = skid_full_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    uart_rx_pop_d = 1'b0;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = wb_regwrite_q;
    wb_aorf_d     = wb_aorf_q;
    wb_rdist_d    = wb_rdist_q;
    wb_data_d     = wb_data_q;
    tok_c         = act_q;
    mem_data_c    = '0;
    uart_data_c   = '0;
    start_c       = 1'b0;
    go_done_c     = 1'b0;
    // ready low means the strobe is a protocol violation and is dropped
    accept_c      = distinct && ready_q;

    case (state_q)
      IDLE: begin
        if (skid_full_q) begin
          tok_c       = skid_q;
          skid_full_d = 1'b0;
          start_c     = 1'b1;
        end else if (accept_c) begin
          tok_c   = in_tok_c;
          start_c = 1'b1;
        end
        if (start_c) begin
          act_d = tok_c;
          if (tok_c.memread || tok_c.memwrite) begin
            state_d     = MEM_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = tok_c.memwrite;
            mem_addr_d  = tok_c.result[DATA_MEM_WIDTH-1:0];
            mem_wdata_d = tok_c.register_data;
          end else if (tok_c.uarttoreg) begin
`ifdef MEM_ACCESS_UART_RX_EN
            state_d = UART_WAIT;
`else
            go_done_c = 1'b1;
`endif
          end else begin
            go_done_c = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          mem_data_c  = mem_rdata;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          go_done_c   = 1'b1;
        end
      end
      UART_WAIT: begin
`ifdef MEM_ACCESS_UART_RX_EN
        if (uart_rx_valid) begin
          uart_data_c   = XLEN'(uart_rx_data);
          uart_rx_pop_d = 1'b1;
          go_done_c     = 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept_c && ((state_q != IDLE) || skid_full_q)) begin
      skid_d      = in_tok_c;
      skid_full_d = 1'b1;
    end

    if (go_done_c) begin
      state_d       = DONE;
      wb_valid_d    = 1'b1;
      wb_regwrite_d = tok_c.regwrite;
      wb_aorf_d     = tok_c.aorf;
      wb_rdist_d    = tok_c.rdist;
      wb_data_d     = wb_data_c;
    end

    ready_d = !skid_full_d;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      act_q         <= '0;
      skid_q        <= '0;
      skid_full_q   <= 1'b0;
      ready_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      uart_rx_pop_q <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_aorf_q     <= 1'b0;
      wb_rdist_q    <= '0;
      wb_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      act_q         <= act_d;
      skid_q        <= skid_d;
      skid_full_q   <= skid_full_d;
      ready_q       <= ready_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      uart_rx_pop_q <= uart_rx_pop_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_aorf_q     <= wb_aorf_d;
      wb_rdist_q    <= wb_rdist_d;
      wb_data_q     <= wb_data_d;
    end
  end

  assign ready       = ready_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign uart_rx_pop = uart_rx_pop_q;
  assign wb_valid    = wb_valid_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_AorF     = wb_aorf_q;
  assign wb_rdist    = wb_rdist_q;
  assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU, load, store, skid, link, UART and reset-abort cases.
module tb_mem_access;

  logic        CLK;
  logic        reset;
  logic        distinct;
  logic        AorF, RegWrite, MemWrite, MemRead, UARTtoReg;
  logic [1:0]  MemtoReg;
  logic [31:0] result, register_data;
  logic [4:0]  rdist;
  logic [4:0]  pc1;
  logic        ready, mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_pop;
  logic        wb_valid, wb_regwrite, wb_AorF;
  logic [4:0]  wb_rdist;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access #(.INST_MEM_WIDTH(5), .DATA_MEM_WIDTH(16)) dut (
    .CLK(CLK), .reset(reset), .distinct(distinct),
    .AorF(AorF), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .UARTtoReg(UARTtoReg), .MemtoReg(MemtoReg), .result(result),
    .register_data(register_data), .rdist(rdist), .pc1(pc1),
    .ready(ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_pop(uart_rx_pop),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_AorF(wb_AorF),
    .wb_rdist(wb_rdist), .wb_data(wb_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic tok(input logic aorf, input logic rw, input logic mw, input logic mr,
                     input logic u2r, input logic [1:0] mtr, input logic [31:0] res,
                     input logic [31:0] rd, input logic [4:0] dst, input logic [4:0] pc);
    AorF = aorf; RegWrite = rw; MemWrite = mw; MemRead = mr; UARTtoReg = u2r;
    MemtoReg = mtr; result = res; register_data = rd; rdist = dst; pc1 = pc;
  endtask

  initial begin
    reset = 1'b0; distinct = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    uart_rx_valid = 1'b0; uart_rx_data = '0;
    tok(0, 0, 0, 0, 0, 2'd0, 32'h0, 32'h0, 5'd0, 5'd0);

    // reset state
    tick; tick;
    chk("rst_ready", ready, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_pop", uart_rx_pop, 0);
    reset = 1'b1;
    tick;
    chk("ready_after_rst", ready, 1);

    // ALU token: one cycle latency
    tok(1, 1, 0, 0, 0, 2'd0, 32'h12345678, 32'h0, 5'd5, 5'd0);
    distinct = 1'b1;
    tick;
    distinct = 1'b0;
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_data", wb_data, 32'h12345678);
    chk("alu_wb_rdist", wb_rdist, 5);
    chk("alu_wb_regwrite", wb_regwrite, 1);
    chk("alu_wb_aorf", wb_AorF, 1);
    tick;
    chk("alu_wb_drop", wb_valid, 0);

    // load with ack on the third request cycle
    tok(0, 1, 0, 1, 0, 2'd1, 32'h00000010, 32'h0, 5'd7, 5'd0);
    distinct = 1'b1;
    tick;
    distinct = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ld_req", mem_req, 1);
      chk("ld_addr", mem_addr, 32'h0010);
      chk("ld_we", mem_we, 0);
      chk("ld_no_wb", wb_valid, 0);
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; end
      tick;
    end
    mem_ack = 1'b0;
    chk("ld_req_drop", mem_req, 0);
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    chk("ld_wb_rdist", wb_rdist, 7);
    tick;
    chk("ld_wb_drop", wb_valid, 0);

    // store, zero-wait ack, address truncation
    tok(0, 0, 1, 0, 0, 2'd0, 32'h55550020, 32'hCAFEF00D, 5'd3, 5'd0);
    distinct = 1'b1;
    tick;
    distinct = 1'b0;
    chk("st_req", mem_req, 1);
    chk("st_we", mem_we, 1);
    chk("st_wdata", mem_wdata, 32'hCAFEF00D);
    chk("st_addr", mem_addr, 32'h0020);
    chk("st_no_wb", wb_valid, 0);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_regwrite", wb_regwrite, 0);
    chk("st_wb_data", wb_data, 32'h55550020);
    chk("st_req_drop", mem_req, 0);
    tick;

    // second token in the ack cycle goes to skid; strobe while not ready is dropped
    tok(0, 1, 0, 1, 0, 2'd1, 32'h00000040, 32'h0, 5'd9, 5'd0);
    distinct = 1'b1;
    tick;
    chk("sk_req", mem_req, 1);
    tok(1, 1, 0, 0, 0, 2'd0, 32'h0BADCAFE, 32'h0, 5'd10, 5'd0);
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    tick;
    mem_ack = 1'b0;
    chk("sk_ready_low", ready, 0);
    chk("sk_a_valid", wb_valid, 1);
    chk("sk_a_data", wb_data, 32'h11112222);
    chk("sk_a_rdist", wb_rdist, 9);
    tok(0, 1, 0, 0, 0, 2'd0, 32'h77777777, 32'h0, 5'd20, 5'd0);
    tick;
    distinct = 1'b0;
    chk("sk_bubble", wb_valid, 0);
    chk("sk_bubble_ready", ready, 0);
    tick;
    chk("sk_b_valid", wb_valid, 1);
    chk("sk_b_data", wb_data, 32'h0BADCAFE);
    chk("sk_b_rdist", wb_rdist, 10);
    chk("sk_ready_high", ready, 1);
    tick;
    chk("sk_b_drop", wb_valid, 0);
    tick;
    chk("sk_dropped_tok", wb_valid, 0);

    // strobe in the DONE cycle, link write-back
    tok(0, 1, 0, 0, 0, 2'd0, 32'h00000ABC, 32'h0, 5'd1, 5'd0);
    distinct = 1'b1;
    tick;
    chk("dn_c_valid", wb_valid, 1);
    chk("dn_c_data", wb_data, 32'h00000ABC);
    tok(0, 1, 0, 0, 0, 2'd2, 32'hFFFFFFFF, 32'h0, 5'd31, 5'h1B);
    tick;
    distinct = 1'b0;
    chk("dn_bubble", wb_valid, 0);
    chk("dn_ready_low", ready, 0);
    tick;
    chk("dn_d_valid", wb_valid, 1);
    chk("dn_d_link", wb_data, 32'h0000001B);
    chk("dn_d_rdist", wb_rdist, 31);
    chk("dn_ready_high", ready, 1);
    tick;

    // UART receive
    tok(0, 1, 0, 0, 1, 2'd0, 32'h00000999, 32'h0, 5'd12, 5'd0);
`ifdef MEM_ACCESS_UART_RX_EN
    distinct = 1'b1;
    tick;
    distinct = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ua_wait_valid", wb_valid, 0);
      chk("ua_wait_pop", uart_rx_pop, 0);
      tick;
    end
    uart_rx_valid = 1'b1; uart_rx_data = 8'h41;
    tick;
    uart_rx_valid = 1'b0;
    chk("ua_pop", uart_rx_pop, 1);
    chk("ua_wb_valid", wb_valid, 1);
    chk("ua_wb_data", wb_data, 32'h00000041);
    chk("ua_wb_rdist", wb_rdist, 12);
    tick;
    chk("ua_pop_once", uart_rx_pop, 0);
    chk("ua_wb_drop", wb_valid, 0);
`else
    uart_rx_valid = 1'b1; uart_rx_data = 8'h41;
    distinct = 1'b1;
    tick;
    distinct = 1'b0;
    chk("ua_wb_valid", wb_valid, 1);
    chk("ua_wb_data", wb_data, 32'h00000000);
    chk("ua_no_pop", uart_rx_pop, 0);
    tick;
    uart_rx_valid = 1'b0;
    chk("ua_wb_drop", wb_valid, 0);
    chk("ua_no_pop2", uart_rx_pop, 0);
`endif
    tick;

    // reset during MEM_WAIT aborts asynchronously
    tok(0, 1, 0, 1, 0, 2'd1, 32'h00000080, 32'h0, 5'd4, 5'd0);
    distinct = 1'b1;
    tick;
    distinct = 1'b0;
    chk("ra_req", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("ra_req_async", mem_req, 0);
    chk("ra_ready", ready, 0);
    tick;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("ra_no_wb", wb_valid, 0);
      chk("ra_no_req", mem_req, 0);
    end
    chk("ra_ready_back", ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
